// File: rtl/alu_logic_unit_if.sv
// Handshake bus for alu_logic_unit: operation request side and result side.
// The execute stage holds the master modport; the logic unit holds the slave modport.
interface alu_logic_unit_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  src1;
    logic [XLEN-1:0]  src2;
    logic [3:0]       ControlOpt;
    logic             word;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result_out;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, src1, src2, ControlOpt, word, in_tag, out_ready,
        input  in_ready, out_valid, result_out, out_tag
    );

    modport slave (
        input  in_valid, src1, src2, ControlOpt, word, in_tag, out_ready,
        output in_ready, out_valid, result_out, out_tag
    );
endinterface

// File: rtl/alu_logic_unit.sv
// Pipelined bitwise-logic unit: each accepted op is computed and queued with its tag.
// Define LOGIC_ZBB_EN to implement ANDN/ORN/XNOR (opcodes 3-5); otherwise they yield 0.
module alu_logic_unit #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    alu_logic_unit_if.slave    bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  res_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             push, pop;
    logic [XLEN-1:0]  raw, res;

    function automatic logic [XLEN-1:0] logic_op(input logic [3:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        case (op)
            4'd0: return a & b;
            4'd1: return a ^ b;
            4'd2: return a | b;
`ifdef LOGIC_ZBB_EN
            4'd3: return a & ~b;
            4'd4: return a | ~b;
            4'd5: return ~(a ^ b);
`endif
            default: return '0;
        endcase
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign raw = logic_op(bus.ControlOpt, bus.src1, bus.src2);

    // Bitwise ops leave the low word independent of the high operand bits,
    // so the W-form is just the full result with bit 31 sign-extended.
    generate
        if (XLEN == 64) begin : g_rv64
            assign res = bus.word ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;
        end else begin : g_rv32
            assign res = raw;
        end
    endgenerate

    assign bus.in_ready  = (count != CW'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign push = bus.in_valid  & bus.in_ready  & ~flush;
    assign pop  = bus.out_valid & bus.out_ready & ~flush;

    assign bus.result_out = bus.out_valid ? res_mem[rd_ptr] : '0;
    assign bus.out_tag    = bus.out_valid ? tag_mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is unreset; outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[wr_ptr] <= res;
            tag_mem[wr_ptr] <= bus.in_tag;
        end
    end
endmodule

// File: tb/tb_alu_logic_unit.sv
// Directed bench for alu_logic_unit (XLEN=64, DEPTH=2, TAG_W=5).
// Inputs change and outputs are sampled on the falling edge; the DUT updates on the rising edge.
module tb_alu_logic_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    int   total = 0;
    int   passed = 0;

    alu_logic_unit_if #(.XLEN(64), .TAG_W(5)) bus ();

    alu_logic_unit #(.XLEN(64), .DEPTH(2), .TAG_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef LOGIC_ZBB_EN
    localparam logic [63:0] ANDN_EXP = 64'h0000_0000_0000_00F0;
    localparam logic [63:0] XNOR_EXP = 64'hFFFF_FFFF_FFFF_FF0F;
`else
    localparam logic [63:0] ANDN_EXP = 64'h0;
    localparam logic [63:0] XNOR_EXP = 64'h0;
`endif

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", name, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
        bus.in_valid   = v;
        bus.ControlOpt = op;
        bus.word       = w;
        bus.src1       = a;
        bus.src2       = b;
        bus.in_tag     = tag;
    endtask

    task automatic head(input string name, input logic [63:0] res, input logic [4:0] tag);
        chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({name, "_res"}, bus.result_out, res);
        chk({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
    endtask

    initial begin
        drive(1'b0, 4'd0, 1'b0, 64'h0, 64'h0, 5'd0);
        bus.out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_result", bus.result_out, 64'd0);
        chk("rst_tag", 64'(bus.out_tag), 64'd0);
        @(negedge clk) rst = 1'b0;

        // Basic ops, one cycle latency, streaming with out_ready=1
        bus.out_ready = 1'b1;
        drive(1'b1, 4'd0, 1'b0, 64'hF0F0_0000_FFFF_0000, 64'hFF00_FF00_F0F0_F0F0, 5'd1);
        chk("and_same_cycle", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        head("and", 64'hF000_0000_F0F0_0000, 5'd1);
        bus.ControlOpt = 4'd1; bus.in_tag = 5'd2;
        @(negedge clk);
        head("xor", 64'h0FF0_FF00_0F0F_F0F0, 5'd2);
        bus.ControlOpt = 4'd2; bus.in_tag = 5'd3;
        @(negedge clk);
        head("or", 64'hFFF0_FF00_FFFF_F0F0, 5'd3);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("drain_empty", 64'(bus.out_valid), 64'd0);

        // Word mode sign extension
        drive(1'b1, 4'd2, 1'b1, 64'h0000_0000_8000_0000, 64'h0, 5'd4);
        @(negedge clk);
        head("orw", 64'hFFFF_FFFF_8000_0000, 5'd4);
        bus.word = 1'b0; bus.in_tag = 5'd5;
        @(negedge clk);
        head("or_nw", 64'h0000_0000_8000_0000, 5'd5);

        // Zbb ops and unused opcode
        drive(1'b1, 4'd3, 1'b0, 64'hFF, 64'h0F, 5'd6);
        @(negedge clk);
        head("andn", ANDN_EXP, 5'd6);
        bus.ControlOpt = 4'd5; bus.in_tag = 5'd7;
        @(negedge clk);
        head("xnor", XNOR_EXP, 5'd7);
        bus.ControlOpt = 4'd9; bus.in_tag = 5'd8;
        @(negedge clk);
        head("op9", 64'h0, 5'd8);
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Back-pressure: tags 1,2,3 with out_ready=0
        bus.out_ready = 1'b0;
        drive(1'b1, 4'd2, 1'b0, 64'h11, 64'h0, 5'd1);
        @(negedge clk);
        chk("bp1_in_ready", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 4'd2, 1'b0, 64'h22, 64'h0, 5'd2);
        @(negedge clk);
        chk("bp2_in_ready", 64'(bus.in_ready), 64'd0);
        head("bp2_head", 64'h11, 5'd1);
        drive(1'b1, 4'd2, 1'b0, 64'h33, 64'h0, 5'd3);
        @(negedge clk);
        chk("bp3_in_ready", 64'(bus.in_ready), 64'd0);
        head("bp3_hold", 64'h11, 5'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("pop_full_in_ready", 64'(bus.in_ready), 64'd1);
        head("pop_full", 64'h22, 5'd2);
        @(negedge clk);
        chk("pushpop_in_ready", 64'(bus.in_ready), 64'd1);
        head("pushpop", 64'h33, 5'd3);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drained", 64'(bus.out_valid), 64'd0);

        // Flush with a full queue and an offer
        bus.out_ready = 1'b0;
        drive(1'b1, 4'd0, 1'b0, 64'hFF, 64'hFF, 5'd9);
        @(negedge clk);
        bus.in_tag = 5'd10;
        @(negedge clk);
        chk("pre_flush_full", 64'(bus.in_ready), 64'd0);
        flush = 1'b1; bus.in_tag = 5'd11;
        @(negedge clk);
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_result", bus.result_out, 64'd0);
        chk("flush_tag", 64'(bus.out_tag), 64'd0);

        // Flush while not full: the offered op must not be pushed
        drive(1'b1, 4'd2, 1'b0, 64'h5, 64'h0, 5'd12);
        @(negedge clk);
        flush = 1'b1; bus.in_tag = 5'd13;
        @(negedge clk);
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush1_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("flush1_stays_empty", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset mid-stream
        drive(1'b1, 4'd1, 1'b0, 64'hA5, 64'h0, 5'd14);
        @(negedge clk);
        bus.in_valid = 1'b0;
        head("pre_rst", 64'hA5, 5'd14);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_result", bus.result_out, 64'd0);
        chk("arst_tag", 64'(bus.out_tag), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk) rst = 1'b0;
        drive(1'b1, 4'd0, 1'b0, 64'hC3, 64'h0F, 5'd15);
        @(negedge clk);
        bus.in_valid = 1'b0;
        head("post_rst", 64'h03, 5'd15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_logic_unit.md
# alu_logic_unit

Parametrised, pipelined bitwise-logic unit for the NPC execute stage, successor to the combinational AND/XOR/OR selector. Each accepted operation is registered into a small result queue, so the execute stage gets a valid/ready handshake, a one-cycle registered result, tag pass-through for writeback matching, RV64 word-mode results and a synchronous flush.

## Interface
- XLEN, 64: datapath width; legal values are 32 and 64.
- DEPTH, 2: result-queue entries; power of two, at least 2.
- TAG_W, 5: width of the opaque tag carried alongside each operation.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- flush  in  1  synchronous; discards all queued results and any operation offered this cycle.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept; equals queue not full.
- src1  in  XLEN  operand 1.
- src2  in  XLEN  operand 2.
- ControlOpt  in  4  opcode: 0 AND, 1 XOR, 2 OR, 3 ANDN, 4 ORN, 5 XNOR; any other value produces result 0.
- word  in  1  RV64 W-form; ignored when XLEN=32.
- in_tag  in  TAG_W  tag for the operation.
- out_valid  out  1  queue head valid.
- out_ready  in  1  consumer accepts the head.
- result_out  out  XLEN  head result; 0 when out_valid=0.
- out_tag  out  TAG_W  head tag; 0 when out_valid=0.

## Operation
- Accept: in_valid & in_ready & ~flush. The result is computed combinationally and written at the tail on that edge.
- Opcode results:
  - ANDN = src1 & ~src2.
  - ORN = src1 | ~src2.
  - XNOR = ~(src1 ^ src2).
- Word mode (XLEN=64, word=1): compute the 32-bit result from src1[31:0] and src2[31:0], then sign-extend bit 31 into [63:32].
- Release: out_valid & out_ready pops the head.
- Queue: circular buffer with read pointer, write pointer and count. Count width is clog2(DEPTH+1); the pointers wrap from DEPTH-1 to 0.
- Simultaneous push and pop:
  - Count is unchanged; both pointers advance.
  - When the queue is full, in_ready=0, so no push occurs in that cycle. There is no same-cycle pass-through.
- Empty with a push: out_valid rises on the next cycle, never in the same cycle.
- flush: on the next edge, count and both pointers become 0 and any simultaneous push or pop is ignored. flush has priority over all other actions.
- rst (asynchronous, mid-operation allowed): queue empties immediately.
- Reset state:
  - out_valid=0, in_ready=1.
  - result_out=0, out_tag=0.
  - Queue storage does not need resetting; outputs are gated by out_valid.
- Unused opcodes 6–15 are accepted normally and produce result 0 with their tag.

## Timing
- Latency: accept on edge N gives out_valid=1 with that result from N+1 onward, if the queue was empty at N.
- Throughput: one operation per cycle while out_ready=1.
- With DEPTH=2 and out_ready held 0, exactly 2 operations are accepted; in_ready falls after the second accept edge.
- in_ready and out_valid are decoded only from registered count; there are no combinational paths from in_valid or out_ready.
- Outputs are held stable while out_valid=1 and out_ready=0.

## Configuration
- LOGIC_ZBB_EN defined:
  - opcodes 3–5 (ANDN, ORN, XNOR) are implemented.
- LOGIC_ZBB_EN undefined:
  - opcodes 3–5 fall into the default and produce 0, like 6–15.
  - The inverted-operand logic is not synthesised.
  - The queue and handshake are identical in both builds.

## Test plan
- Basic ops, XLEN=64, out_ready=1: src1=0xF0F0_0000_FFFF_0000, src2=0xFF00_FF00_F0F0_F0F0. Required responses:
  - AND gives 0xF000_0000_F0F0_0000.
  - XOR gives 0x0FF0_FF00_0F0F_F0F0.
  - OR gives 0xFFF0_FF00_FFFF_F0F0.
  - Each result appears one cycle after acceptance, with its tag.
- Word mode: src1=0x0000_0000_8000_0000, src2=0, OR, word=1 → 0xFFFF_FFFF_8000_0000. The same operands with word=0 → 0x0000_0000_8000_0000.
- Back-pressure, DEPTH=2, out_ready=0: offer tags 1,2,3 back-to-back.
  - Tags 1 and 2 are accepted; in_ready=0 while tag 3 is held.
  - Raise out_ready: outputs appear in order 1,2,3 with no loss or duplication.
- Full with simultaneous pop:
  - While full, assert out_ready and in_valid: one pop, no push, count drops to 1.
  - On the next cycle a push and a pop together keep count=1.
- Flush and reset: with 2 entries queued, flush=1 for one cycle, together with in_valid=1 → next cycle out_valid=0 and in_ready=1, and the flushed offer is lost. rst asserted mid-stream → out_valid, result_out and out_tag are 0 immediately, without waiting for a clock edge.
- Configuration: ANDN with src1=0xFF, src2=0x0F → 0xF0 with LOGIC_ZBB_EN defined, 0 without. Opcode 9 → 0 in both builds.
